training_sample_feeder: RTL

//   Upstream stage of learningNeuron. Accepts training samples as a serial word stream,
//   one word per handshake: N_INPUTS inputs followed by one target word.

---
 rtl/nn_pkg.sv | 15 +
 rtl/training_sample_feeder_hold_timer.sv | 25 ++
 rtl/training_sample_feeder.sv | 119 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared word/vector types for learningNeuron, backPropperStart and the sample feeder.
package nn_pkg;
    localparam int WIDTH    = 32;
    localparam int N_INPUTS = 32;
    localparam int SEL_W    = $clog2(N_INPUTS);
    localparam int IDX_W    = $clog2(N_INPUTS + 1);

    typedef logic [WIDTH-1:0] word_t;
    typedef word_t [N_INPUTS-1:0] vec_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } pres_state_t;
endpackage

// File: rtl/training_sample_feeder_hold_timer.sv
// Counts enabled presentation cycles; done flags the last enabled cycle of a sample.
module hold_timer #(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic             en,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);
    assign done = en && (cnt == CNT_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || start || done) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/training_sample_feeder.sv
// Serial-to-parallel training sample feeder: assembly bank plus presentation registers.
//   state      | meaning
//   ST_IDLE    | no live sample on in_vec/target
//   ST_PRESENT | sample live, hold timer counting enabled cycles
module training_sample_feeder
    import nn_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             hold_en,
    output logic [N_INPUTS-1:0][WIDTH-1:0]   in_vec,
    output logic [WIDTH-1:0]                 target,
    output logic                             vec_valid,
    output logic                             vec_first,
    output logic                             vec_done,
    output logic [CNT_W-1:0]                 samples_presented
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    vec_t              asm_vec;
    word_t             asm_tgt;
    logic [IDX_W-1:0]  wr_idx;
    logic              asm_full;
    pres_state_t       state, state_nxt;
    logic              accept, last_word, swap, timer_en, timer_done;
    logic [HOLD_W-1:0] hold_cnt;

    assign wr_ready  = !asm_full;
    assign accept    = wr_valid && wr_ready && !flush;
    assign last_word = (wr_idx == IDX_W'(N_INPUTS));
    assign timer_en  = vec_valid && hold_en && !flush;
    assign vec_done  = timer_done;
    // A queued sample replaces the live one on the same edge it finishes: no bubble.
    assign swap      = asm_full && (!vec_valid || vec_done) && !flush;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (HOLD_W)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .start (swap),
        .en    (timer_en),
        .done  (timer_done),
        .cnt   (hold_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else if (swap) begin
            state_nxt = ST_PRESENT;
        end else if (vec_done) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        vec_valid = (state == ST_PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_vec           <= '0;
            asm_tgt           <= '0;
            wr_idx            <= '0;
            asm_full          <= 1'b0;
            in_vec            <= '0;
            target            <= '0;
            vec_first         <= 1'b0;
            samples_presented <= '0;
        end else begin
            vec_first <= swap;
            if (flush) begin
                wr_idx   <= '0;
                asm_full <= 1'b0;
            end else begin
                if (accept) begin
                    if (last_word) begin
                        asm_tgt  <= wr_data;
                        asm_full <= 1'b1;
                        wr_idx   <= '0;
                    end else begin
                        asm_vec[wr_idx[SEL_W-1:0]] <= wr_data;
                        wr_idx <= wr_idx + IDX_W'(1);
                    end
                end
                if (swap) begin
                    in_vec   <= asm_vec;
                    target   <= asm_tgt;
                    asm_full <= 1'b0;
                end
                if (vec_done) begin
                    samples_presented <= samples_presented + CNT_W'(1);
                end
            end
        end
    end

    a_done_at_last: assert property (@(posedge clk) disable iff (!rst_n)
        vec_done |-> (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)));
endmodule
